// File: rtl/div_unit.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// valid/ready on both sides, alu-compatible sel encoding for div/rem ops.
module div_unit #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [4:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, nstate;
  logic           prep;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_q, b_q;
  logic [4:0]     sel_q;
  logic [N-1:0]   rq, qq, dv;
  logic           neg_q, neg_r;
  logic [N-1:0]   res_q;

  // op decode of the latched sel
  logic op_ok, word, sgn, is_rem;

  // decode sel into op attributes; unsupported codes clear op_ok
  always_comb begin
    op_ok  = 1'b1;
    word   = 1'b0;
    sgn    = 1'b0;
    is_rem = 1'b0;
    case (sel_q)
      5'd3:    sgn = 1'b1;
      5'd4:    ;
      5'd5:    begin sgn = 1'b1; is_rem = 1'b1; end
      5'd6:    is_rem = 1'b1;
      5'd25:   begin word = 1'b1; sgn = 1'b1; end
      5'd26:   word = 1'b1;
      5'd27:   begin word = 1'b1; sgn = 1'b1; is_rem = 1'b1; end
      5'd28:   begin word = 1'b1; is_rem = 1'b1; end
      default: op_ok = 1'b0;
    endcase
  end

  // operand prep: width extension, magnitudes, signs, divide-by-zero result
  logic [N-1:0] a_ext, b_ext, a_mag, b_mag, q_init, zero_res;
  logic         sa, sb, b_zero;

  always_comb begin
    if (word) begin
      a_ext = sgn ? {{(N-32){a_q[31]}}, a_q[31:0]} : {{(N-32){1'b0}}, a_q[31:0]};
      b_ext = sgn ? {{(N-32){b_q[31]}}, b_q[31:0]} : {{(N-32){1'b0}}, b_q[31:0]};
    end else begin
      a_ext = a_q;
      b_ext = b_q;
    end
    sa     = sgn & a_ext[N-1];
    sb     = sgn & b_ext[N-1];
    a_mag  = sa ? (~a_ext + 1'b1) : a_ext;
    b_mag  = sb ? (~b_ext + 1'b1) : b_ext;
    b_zero = (b_ext == '0);
    // W dividends sit in the top half so 32 shifts bring the quotient to the low half
    q_init = word ? {a_mag[31:0], {(N-32){1'b0}}} : a_mag;
    if (!is_rem)
      zero_res = '1;
    else if (word)
      zero_res = {{(N-32){a_q[31]}}, a_q[31:0]};
    else
      zero_res = a_q;
  end

  // one restoring step plus sign fixup of the step's outcome
  logic [N:0]   shifted;
  logic         take;
  logic [N-1:0] r_nx, q_nx, qf, rf, pick, fix_res;

  always_comb begin
    shifted = {rq, qq[N-1]};
    take    = (shifted >= {1'b0, dv});
    r_nx    = take ? N'(shifted - {1'b0, dv}) : shifted[N-1:0];
    q_nx    = {qq[N-2:0], take};
    qf      = neg_q ? (~q_nx + 1'b1) : q_nx;
    rf      = neg_r ? (~r_nx + 1'b1) : r_nx;
    pick    = is_rem ? rf : qf;
    fix_res = word ? {{(N-32){pick[31]}}, pick[31:0]} : pick;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // next-state logic; flush overrides every other transition
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (in_valid) nstate = CALC;
      CALC: begin
        if (prep) begin
          if (!op_ok || b_zero) nstate = DONE;
        end else if (cnt == '0) begin
          nstate = DONE;
        end
      end
      DONE: if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (flush) nstate = IDLE;
  end

  // datapath: latch operands, prep cycle, then K shift/subtract steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prep  <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
      rq    <= '0;
      qq    <= '0;
      dv    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else if (state == IDLE) begin
      if (in_valid && !flush) begin
        a_q   <= A;
        b_q   <= B;
        sel_q <= sel;
        prep  <= 1'b1;
      end
    end else if (state == CALC) begin
      if (prep) begin
        prep <= 1'b0;
        if (!op_ok) begin
          res_q <= '0;
        end else if (b_zero) begin
          res_q <= zero_res;
        end else begin
          rq    <= '0;
          qq    <= q_init;
          dv    <= b_mag;
          cnt   <= word ? CW'(31) : CW'(N-1);
          neg_q <= sa ^ sb;
          neg_r <= sa;
        end
      end else begin
        rq <= r_nx;
        qq <= q_nx;
        if (cnt == '0) res_q <= fix_res;
        else           cnt   <= cnt - 1'b1;
      end
    end
  end

  // handshake outputs; res only shows the result while in DONE
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    res       = (state == DONE) ? res_q : '0;
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [63:0] A, B, res;
  logic [4:0]  sel;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit #(.N(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  sel;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // issue one op, measure edges from accept to out_valid, check result, retire it
  task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] s, input logic [63:0] exp, input int lat);
    int n;
    @(negedge clk);
    A = a; B = b; sel = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("lat[%0d]", id), 64'(n), 64'(lat));
    check($sformatf("res[%0d]", id), res, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("retire[%0d]", id), {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int n;
    logic seen;
    vecs[0]  = '{64'd100, 64'd7, 5'd4, 64'd14, 65};
    vecs[1]  = '{64'd100, 64'd7, 5'd6, 64'd2, 65};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd25, 64'hFFFF_FFFF_8000_0000, 33};
    vecs[5]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd27, 64'd0, 33};
    vecs[6]  = '{64'd12345, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{64'd5, 64'd0, 5'd6, 64'd5, 1};
    vecs[8]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'h8000_0000_0000_0000, 65};
    vecs[9]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd0, 65};
    vecs[10] = '{64'hDEAD_0000_0000_000A, 64'h1234_0000_0000_0003, 5'd26, 64'd3, 33};
    vecs[11] = '{64'h0000_0000_FFFF_FFFF, 64'd2, 5'd28, 64'd1, 33};
    vecs[12] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 5'd26, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[13] = '{64'd50, 64'd5, 5'd7, 64'd0, 1};
    vecs[14] = '{64'd9, 64'hFFFF_FFFF_0000_0000, 5'd25, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[15] = '{64'h0000_0001_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd27, 64'hFFFF_FFFF_8000_0005, 1};
    vecs[16] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd5, 64'd1, 65};
    vecs[17] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[18] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd4, 64'h5555_5555_5555_5555, 65};
    vecs[19] = '{64'h0000_0000_FFFF_FF9C, 64'd7, 5'd25, 64'hFFFF_FFFF_FFFF_FFF2, 33};
    vecs[20] = '{64'h0000_0000_FFFF_FF9C, 64'd7, 5'd27, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[21] = '{64'h8000_0000_0000_0000, 64'd0, 5'd5, 64'h8000_0000_0000_0000, 1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; sel = '0;
    #1;
    check("reset_ctl", {61'd0, in_ready, out_valid, busy}, 64'd4);
    check("reset_res", res, 64'd0);
    #20;
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 22; i++)
      run_op(i, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, vecs[i].lat);

    // result held while WB stalls
    @(negedge clk);
    A = 64'd100; B = 64'd7; sel = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("stall_lat", 64'(n), 64'd65);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall_ctl[%0d]", c), {61'd0, in_ready, out_valid, busy}, 64'd3);
      check($sformatf("stall_res[%0d]", c), res, 64'd14);
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("stall_retire", {62'd0, out_valid, in_ready}, 64'd1);

    // flush beats a same-cycle accept
    @(negedge clk);
    A = 64'd9; B = 64'd3; sel = 5'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept", {61'd0, in_ready, out_valid, busy}, 64'd4);

    // flush in CALC cycle 20
    @(negedge clk);
    A = 64'd1000; B = 64'd3; sel = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 19; c++) @(posedge clk);
    check("pre_flush_busy", {63'd0, busy}, 64'd1);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_ctl", {61'd0, in_ready, out_valid, busy}, 64'd4);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", {63'd0, seen}, 64'd0);

    // async reset mid-CALC
    @(negedge clk);
    A = 64'd1000; B = 64'd3; sel = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int c = 0; c < 10; c++) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("arst_ctl", {61'd0, in_ready, out_valid, busy}, 64'd4);
    check("arst_res", res, 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(100, 64'd10, 64'd3, 5'd26, 64'd3, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
